// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states and register constants.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX writing a register the ID instruction reads.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       ex_memrd_i,
    input  logic [4:0] ex_wrreg_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rt_i,
    output logic       lu_hazard_o
);

    always_comb begin
        lu_hazard_o = ex_memrd_i && (ex_wrreg_i != REG_ZERO) &&
                      ((ex_wrreg_i == id_rs_i) || (id_use_rt_i && (ex_wrreg_i == id_rt_i)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority, memory-wait FSM, stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_W      = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rt,
    input  logic        EX_MemRd,
    input  logic [4:0]  EX_WrReg,
    input  logic        EX_branch,
    input  logic        ID_jump,
    input  logic        Mem_MemRd,
    input  logic        Mem_MemWr,
    input  logic        mem_ready,
    output logic        PC_stall,
    output logic        IFID_stall,
    output logic        IFID_flush,
    output logic        IDEX_stall,
    output logic        IDEX_flush,
    output logic        EXMEM_stall,
    output logic        MEMWB_flush,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;

    logic lu_hazard;
    logic mem_op;
    logic tmo;
    logic memhold;

    load_use_detect u_lu (
        .ex_memrd_i  (EX_MemRd),
        .ex_wrreg_i  (EX_WrReg),
        .id_rs_i     (ID_rs),
        .id_rt_i     (ID_rt),
        .id_use_rt_i (ID_use_rt),
        .lu_hazard_o (lu_hazard)
    );

    always_comb begin
        mem_op  = Mem_MemRd | Mem_MemWr;
        tmo     = (state_q == ST_MEMWAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
        memhold = ((state_q == ST_RUN) && mem_op && !mem_ready) ||
                  ((state_q == ST_MEMWAIT) && !mem_ready && !tmo);
    end

    // Outputs act in the same cycle; the async reset masks them before any flop updates.
    always_comb begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_stall  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_stall = 1'b0;
        MEMWB_flush = 1'b0;
        if (reset) begin
            if (memhold) begin
                PC_stall    = 1'b1;
                IFID_stall  = 1'b1;
                IDEX_stall  = 1'b1;
                EXMEM_stall = 1'b1;
                MEMWB_flush = 1'b1;
            end else if (EX_branch) begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
            end else if (lu_hazard) begin
                PC_stall   = 1'b1;
                IFID_stall = 1'b1;
                IDEX_flush = 1'b1;
            end else if (ID_jump) begin
                IFID_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_err_d      = 1'b0;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            ST_RUN: begin
                if (mem_op && !mem_ready) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (tmo) begin
                    state_d   = ST_RUN;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (PC_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors with hand-written expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_WrReg;
    logic        ID_use_rt, EX_MemRd, EX_branch, ID_jump;
    logic        Mem_MemRd, Mem_MemWr, mem_ready;
    logic        PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush;
    logic        mem_err;
    logic [31:0] stall_cycles;

    // {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] BR   = 7'b0010100;
    localparam logic [6:0] MH   = 7'b1101011;
    localparam logic [6:0] JMP  = 7'b0010000;

    typedef struct {
        logic [6:0]  ctl;
        logic        err;
        logic [31:0] sc;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] stall_exp = '0;

    pipe_hazard_ctrl #(.WAIT_W(4), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_use_rt    (ID_use_rt),
        .EX_MemRd     (EX_MemRd),
        .EX_WrReg     (EX_WrReg),
        .EX_branch    (EX_branch),
        .ID_jump      (ID_jump),
        .Mem_MemRd    (Mem_MemRd),
        .Mem_MemWr    (Mem_MemWr),
        .mem_ready    (mem_ready),
        .PC_stall     (PC_stall),
        .IFID_stall   (IFID_stall),
        .IFID_flush   (IFID_flush),
        .IDEX_stall   (IDEX_stall),
        .IDEX_flush   (IDEX_flush),
        .EXMEM_stall  (EXMEM_stall),
        .MEMWB_flush  (MEMWB_flush),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Inputs are applied at the falling edge; push the expectation, then advance one cycle.
    task automatic cyc(input logic [6:0] ctl, input logic err, input string nm);
        exp_t e;
        e.ctl = ctl;
        e.err = err;
        e.sc  = reset ? stall_exp : 32'd0;
        e.nm  = nm;
        sb.push_back(e);
        if (!reset) stall_exp = '0;
        else if (ctl[6]) stall_exp = stall_exp + 32'd1;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_WrReg = 5'd0;
        ID_use_rt = 1'b0; EX_MemRd = 1'b0; EX_branch = 1'b0; ID_jump = 1'b0;
        Mem_MemRd = 1'b0; Mem_MemWr = 1'b0; mem_ready = 1'b0;
    endtask

    // Monitor: compares every output against the oldest expectation, mid-cycle.
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = sb.pop_front();
            act = {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush};
            checks++;
            if (act !== e.ctl || mem_err !== e.err || stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s: ctl=%b err=%b sc=%0d, expected ctl=%b err=%b sc=%0d",
                         e.nm, act, mem_err, stall_cycles, e.ctl, e.err, e.sc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        EX_branch = 1'b1;
        cyc(NONE, 1'b0, "reset_masks_branch");
        reset = 1'b1; EX_branch = 1'b0;
        cyc(NONE, 1'b0, "idle_after_reset");

        // Load-use on rs, then the bubble clears it
        EX_MemRd = 1'b1; EX_WrReg = 5'd8; ID_rs = 5'd8;
        cyc(LU, 1'b0, "lu_rs");
        EX_MemRd = 1'b0;
        cyc(NONE, 1'b0, "lu_released");
        // Load-use on rt only when rt is actually read
        EX_MemRd = 1'b1; EX_WrReg = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9; ID_use_rt = 1'b1;
        cyc(LU, 1'b0, "lu_rt");
        ID_use_rt = 1'b0;
        cyc(NONE, 1'b0, "lu_rt_unused");
        // Register zero never creates a hazard
        EX_WrReg = 5'd0; ID_rs = 5'd0;
        cyc(NONE, 1'b0, "lu_reg0");
        // Jump waits behind a load-use stall
        EX_WrReg = 5'd5; ID_rs = 5'd5; ID_jump = 1'b1;
        cyc(LU, 1'b0, "jump_under_lu");
        EX_MemRd = 1'b0;
        cyc(JMP, 1'b0, "jump_alone");
        clear_inputs();

        EX_branch = 1'b1;
        cyc(BR, 1'b0, "branch");
        EX_MemRd = 1'b1; EX_WrReg = 5'd7; ID_rs = 5'd7;
        cyc(BR, 1'b0, "branch_over_lu");
        clear_inputs();
        cyc(NONE, 1'b0, "idle1");

        // Memory wait: 3 stalled cycles from a clean counter
        reset = 1'b0;
        cyc(NONE, 1'b0, "reset2");
        reset = 1'b1;
        Mem_MemRd = 1'b1;
        cyc(MH, 1'b0, "memwait1");
        cyc(MH, 1'b0, "memwait2");
        cyc(MH, 1'b0, "memwait3");
        mem_ready = 1'b1;
        cyc(NONE, 1'b0, "memwait_done_sc3");
        clear_inputs();
        cyc(NONE, 1'b0, "idle2");

        // Timeout: 15 stalled cycles, release on 16, error pulse once
        Mem_MemWr = 1'b1;
        for (int i = 0; i < 15; i++) cyc(MH, 1'b0, "tmo_hold");
        cyc(NONE, 1'b0, "tmo_release");
        clear_inputs();
        cyc(NONE, 1'b1, "tmo_err_pulse");
        cyc(NONE, 1'b0, "tmo_err_clear");

        // Ready on the timeout cycle is a normal completion
        Mem_MemRd = 1'b1;
        for (int i = 0; i < 15; i++) cyc(MH, 1'b0, "tmo_ready_hold");
        mem_ready = 1'b1;
        cyc(NONE, 1'b0, "tmo_ready_release");
        clear_inputs();
        cyc(NONE, 1'b0, "tmo_ready_no_err");

        // Reset mid-wait aborts it; afterwards the FSM is back in RUN
        Mem_MemRd = 1'b1;
        cyc(MH, 1'b0, "rst_wait1");
        cyc(MH, 1'b0, "rst_wait2");
        reset = 1'b0;
        cyc(NONE, 1'b0, "rst_mid_wait");
        reset = 1'b1; Mem_MemRd = 1'b0; EX_branch = 1'b1;
        cyc(BR, 1'b0, "rst_back_in_run");
        clear_inputs();

        // Branch held during a wait takes effect on the release cycle
        Mem_MemRd = 1'b1; EX_branch = 1'b1;
        cyc(MH, 1'b0, "pend_br_wait1");
        cyc(MH, 1'b0, "pend_br_wait2");
        mem_ready = 1'b1;
        cyc(BR, 1'b0, "pend_br_release");
        clear_inputs();
        cyc(NONE, 1'b0, "idle_end");

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
